// File: rtl/spart_pkg.sv
// ============================================================================
// Module : spart_pkg
// Brief  : Shared types and limits for the SPART transmit path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int SPART_MAX_DATA_W    = 9;
   localparam int SPART_MAX_STOP_BITS = 2;

endpackage

`default_nettype wire

// File: rtl/spart_tx_fifo.sv
// ============================================================================
// Module : spart_tx_fifo
// Brief  : Synchronous FIFO with occupancy counter and dropped-write pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spart_tx_fifo
   import spart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             r_overflow;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign full      = (r_level == c_full_level);
   assign empty     = (r_level == '0);
   assign level     = r_level;
   assign overflow  = r_overflow;
   assign dout      = r_mem[r_rd_ptr];

   // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
   assign w_pop_ok  = pop & ~empty;
   assign w_push_ok = push & (~full | w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= push & ~w_push_ok;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/spart_tx_fifo_uart.sv
// ============================================================================
// Module : spart_tx_fifo_uart
// Brief  : FIFO-buffered async serial transmitter; parity via SPART_TX_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spart_tx_fifo_uart
   import spart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          baud_tick,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          wr_en,
   input  logic                          parity_odd,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy,
   output logic                          overflow,
   output logic                          TxD
);

   localparam int CW = $clog2(SPART_MAX_DATA_W);

`ifdef SPART_TX_PARITY_EN
   localparam int ENTRY_W = DATA_W + 1;
`else
   localparam int ENTRY_W = DATA_W;
`endif

   tx_state_t         r_state, w_state_nx;
   logic              r_txd, w_txd_nx;
   logic [DATA_W-1:0] r_sr, w_sr_nx;
   logic [CW-1:0]     r_bit_cnt, w_cnt_nx;
   logic              r_stop_cnt, w_stop_nx;
   logic              w_pop;
   logic [ENTRY_W-1:0] w_din;
   logic [ENTRY_W-1:0] w_dout;

`ifdef SPART_TX_PARITY_EN
   logic              r_par;
   assign w_din = {parity_odd, wr_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_par <= 1'b0;
      else if (w_pop) r_par <= (^w_dout[DATA_W-1:0]) ^ w_dout[DATA_W];
   end
`else
   logic              w_unused;
   assign w_din    = wr_data;
   assign w_unused = parity_odd;
`endif

   spart_tx_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (wr_en),
      .pop      (w_pop),
      .din      (w_din),
      .dout     (w_dout),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow)
   );

   assign busy = (r_state != IDLE);
   assign TxD  = r_txd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_txd      <= 1'b1;
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_txd      <= w_txd_nx;
         r_sr       <= w_sr_nx;
         r_bit_cnt  <= w_cnt_nx;
         r_stop_cnt <= w_stop_nx;
      end
   end

   // The line register is loaded with the value of the state being entered.
   always_comb begin
      w_state_nx = r_state;
      w_txd_nx   = r_txd;
      w_sr_nx    = r_sr;
      w_cnt_nx   = r_bit_cnt;
      w_stop_nx  = r_stop_cnt;
      w_pop      = 1'b0;
      if (baud_tick) begin
         case (r_state)
            IDLE: begin
               w_txd_nx = 1'b1;
               if (!empty) begin
                  w_pop      = 1'b1;
                  w_state_nx = START;
                  w_txd_nx   = 1'b0;
                  w_sr_nx    = w_dout[DATA_W-1:0];
               end
            end
            START: begin
               w_state_nx = DATA;
               w_txd_nx   = r_sr[0];
               w_sr_nx    = r_sr >> 1;
               w_cnt_nx   = '0;
            end
            DATA: begin
               if (r_bit_cnt == CW'(DATA_W-1)) begin
`ifdef SPART_TX_PARITY_EN
                  w_state_nx = PARITY;
                  w_txd_nx   = r_par;
`else
                  w_state_nx = STOP;
                  w_txd_nx   = 1'b1;
                  w_stop_nx  = 1'b0;
`endif
               end else begin
                  w_txd_nx = r_sr[0];
                  w_sr_nx  = r_sr >> 1;
                  w_cnt_nx = r_bit_cnt + CW'(1);
               end
            end
`ifdef SPART_TX_PARITY_EN
            PARITY: begin
               w_state_nx = STOP;
               w_txd_nx   = 1'b1;
               w_stop_nx  = 1'b0;
            end
`endif
            STOP: begin
               if (r_stop_cnt == 1'(STOP_BITS-1)) begin
                  if (!empty) begin
                     w_pop      = 1'b1;
                     w_state_nx = START;
                     w_txd_nx   = 1'b0;
                     w_sr_nx    = w_dout[DATA_W-1:0];
                  end else begin
                     w_state_nx = IDLE;
                     w_txd_nx   = 1'b1;
                  end
               end else begin
                  w_stop_nx = r_stop_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nx = IDLE;
               w_txd_nx   = 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spart_tx_fifo_uart.sv
// ============================================================================
// Module : tb_spart_tx_fifo_uart
// Brief  : Directed bench for spart_tx_fifo_uart (parity build with SPART_TX_PARITY_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spart_tx_fifo_uart;

`ifdef SPART_TX_PARITY_EN
   localparam int DW = 7;
   localparam int SB = 2;
`else
   localparam int DW = 8;
   localparam int SB = 1;
`endif
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          baud_tick = 1'b0;
   logic          wr_en = 1'b0;
   logic          parity_odd = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          full, empty, busy, overflow, TxD;
   logic [2:0]    level;

   int n_vec = 0;
   int n_err = 0;

   spart_tx_fifo_uart #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .STOP_BITS  (SB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_tick  (baud_tick),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .parity_odd (parity_odd),
      .full       (full),
      .empty      (empty),
      .level      (level),
      .busy       (busy),
      .overflow   (overflow),
      .TxD        (TxD)
   );

   always #5 clk = ~clk;

   task automatic wr(input logic [DW-1:0] d, input logic odd);
      @(negedge clk);
      wr_data = d; parity_odd = odd; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic tick(input int gap);
      repeat (gap) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (TxD !== 1'b1)      begin n_err++; $display("FAIL rst_txd got %b want 1", TxD); end
      n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      n_vec++; if (full !== 1'b0)     begin n_err++; $display("FAIL rst_full got %b want 0", full); end
      n_vec++; if (empty !== 1'b1)    begin n_err++; $display("FAIL rst_empty got %b want 1", empty); end
      n_vec++; if (level !== 3'd0)    begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", overflow); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef SPART_TX_PARITY_EN
   task automatic test_parity;
      logic [DW-1:0] w;
      logic          exp;
      w = 7'h03;
      for (int p = 0; p < 2; p++) begin
         wr(w, (p == 0));
         for (int i = 0; i < 11; i++) begin
            tick(2);
            if (i == 0)      exp = 1'b0;
            else if (i <= 7) exp = w[i-1];
            else if (i == 8) exp = (p == 0);
            else             exp = 1'b1;
            n_vec++; if (TxD !== exp)   begin n_err++; $display("FAIL par%0d_bit%0d got %b want %b", p, i, TxD, exp); end
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL par%0d_busy%0d got %b want 1", p, i, busy); end
         end
         tick(2);
         n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL par%0d_end_busy got %b want 0", p, busy); end
      end
   endtask
`else
   task automatic test_single_frame;
      int exp [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      wr(8'hA5, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(15);
         n_vec++; if (TxD !== exp[i][0]) begin n_err++; $display("FAIL a5_bit%0d got %b want %0d", i, TxD, exp[i]); end
         n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL a5_busy%0d got %b want 1", i, busy); end
         if (i == 0) begin
            n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL a5_empty got %b want 1", empty); end
         end
      end
      tick(15);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL a5_end_busy got %b want 0", busy); end
      n_vec++; if (TxD !== 1'b1)  begin n_err++; $display("FAIL a5_end_txd got %b want 1", TxD); end
   endtask

   task automatic test_back_to_back;
      logic exp;
      wr(8'h00, 1'b0);
      wr(8'hFF, 1'b0);
      n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_level got %0d want 2", level); end
      for (int i = 0; i < 20; i++) begin
         tick(3);
         exp = !(i <= 8 || i == 10);
         n_vec++; if (TxD !== exp)   begin n_err++; $display("FAIL b2b_bit%0d got %b want %b", i, TxD, exp); end
         n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy%0d got %b want 1", i, busy); end
         if (i == 0) begin
            n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL b2b_empty0 got %b want 0", empty); end
         end
         if (i == 10) begin
            n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty1 got %b want 1", empty); end
         end
      end
      tick(3);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy got %b want 0", busy); end
   endtask

   task automatic test_overflow;
      wr(8'h11, 1'b0);
      wr(8'h22, 1'b0);
      wr(8'h33, 1'b0);
      wr(8'h44, 1'b0);
      n_vec++; if (level !== 3'd4)    begin n_err++; $display("FAIL ovf_level got %0d want 4", level); end
      n_vec++; if (full !== 1'b1)     begin n_err++; $display("FAIL ovf_full got %b want 1", full); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_pre got %b want 0", overflow); end
      @(negedge clk);
      wr_data = 8'h55; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse got %b want 1", overflow); end
      n_vec++; if (level !== 3'd4)    begin n_err++; $display("FAIL ovf_level2 got %0d want 4", level); end
      @(negedge clk);
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_drop got %b want 0", overflow); end
   endtask

   task automatic test_full_push_pop;
      logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
      logic [7:0] w;
      logic       exp;
      @(negedge clk);
      wr_data = 8'h66; wr_en = 1'b1; baud_tick = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; baud_tick = 1'b0;
      n_vec++; if (level !== 3'd4)    begin n_err++; $display("FAIL fpp_level got %0d want 4", level); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got %b want 0", overflow); end
      n_vec++; if (full !== 1'b1)     begin n_err++; $display("FAIL fpp_full got %b want 1", full); end
      n_vec++; if (TxD !== 1'b0)      begin n_err++; $display("FAIL fpp_start got %b want 0", TxD); end
      n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL fpp_busy got %b want 1", busy); end
      for (int f = 0; f < 5; f++) begin
         w = words[f];
         for (int b = 0; b < 10; b++) begin
            if (f != 0 || b != 0) begin
               tick(1);
               if (b == 0)      exp = 1'b0;
               else if (b == 9) exp = 1'b1;
               else             exp = w[b-1];
               n_vec++; if (TxD !== exp) begin n_err++; $display("FAIL fpp_f%0d_b%0d got %b want %b", f, b, TxD, exp); end
            end
         end
      end
      tick(1);
      n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL fpp_end_busy got %b want 0", busy); end
      n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fpp_end_empty got %b want 1", empty); end
   endtask

   task automatic test_reset_mid;
      wr(8'h00, 1'b0);
      wr(8'h00, 1'b0);
      tick(2);
      tick(2);
      n_vec++; if (TxD !== 1'b0) begin n_err++; $display("FAIL rmid_pre got %b want 0", TxD); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (TxD !== 1'b1)  begin n_err++; $display("FAIL rmid_async_txd got %b want 1", TxD); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_async_busy got %b want 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty got %b want 1", empty); end
      n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rmid_level got %0d want 0", level); end
      for (int i = 0; i < 3; i++) begin
         tick(2);
         n_vec++; if (TxD !== 1'b1)  begin n_err++; $display("FAIL rmid_idle_txd%0d got %b want 1", i, TxD); end
         n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_idle_busy%0d got %b want 0", i, busy); end
      end
   endtask
`endif

   initial begin
      test_reset;
`ifdef SPART_TX_PARITY_EN
      test_parity;
`else
      test_single_frame;
      test_back_to_back;
      test_overflow;
      test_full_push_pop;
      test_reset_mid;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
